// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial-to-parallel frame receiver.
package s2p_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam int W_DEFAULT = 4;
  localparam int QDEPTH    = 2;

endpackage

// File: rtl/s2p_frame_rx_if.sv
// Bus between the serial source / word consumer and the receiver.
interface s2p_frame_rx_if #(parameter int W = 4);

  logic         din;
  logic         sof;
  logic [W-1:0] dout;
  logic         dout_vld;
  logic         dout_rdy;
  logic         frm_err;
  logic         ovf;
  logic         err_clr;

  // Environment side: drives the serial stream and consumes words.
  modport master (
    output din, sof, dout_rdy, err_clr,
    input  dout, dout_vld, frm_err, ovf
  );

  // Receiver side.
  modport slave (
    input  din, sof, dout_rdy, err_clr,
    output dout, dout_vld, frm_err, ovf
  );

endinterface

// File: rtl/s2p_out_queue.sv
// Two-entry output FIFO; entry 0 is the head and drives dout directly,
// so dout is a flop and falls back to zero whenever the queue drains.
module s2p_out_queue import s2p_pkg::*; #(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_rdy,
  input  logic         err_clr,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  output logic         ovf
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         pop;
  logic         full;
  logic         drop;

  // Next queue contents: pop shifts entry 1 to the head, and a pop frees a
  // slot before a same-cycle push so a full queue still accepts the word.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop    = 1'b0;
    full    = (count_q == 2'(QDEPTH));
    pop     = (count_q != 2'd0) && pop_rdy;
    unique case ({push, pop})
      2'b11: begin
        if (count_q == 2'd1) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      2'b01: begin
        e0_d    = e1_q;
        e1_d    = '0;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (full) begin
          drop = 1'b1;
        end else begin
          if (count_q == 2'd0) begin
            e0_d = push_data;
          end else begin
            e1_d = push_data;
          end
          count_d = count_q + 2'd1;
        end
      end
      default: ;
    endcase
    if (err_clr) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout     = e0_q;
  assign dout_vld = (count_q != 2'd0);
  assign ovf      = ovf_q;

endmodule

// File: rtl/s2p_frame_rx.sv
// Serial-to-parallel frame receiver: collects W bits MSB first after each
// frame start, flags frames that restart early and queues finished words.
module s2p_frame_rx import s2p_pkg::*; #(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  s2p_frame_rx_if.slave  bus
);

  localparam int             BW   = $clog2(W);
  localparam logic [BW-1:0] LAST = BW'(W - 1);

  // Bit 0 of the word comes straight from din on the final edge, so the
  // shift register only needs to hold the upper W-1 bits.
  state_e        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [W-1:1]  sr_q, sr_d;
  logic          frm_err_q, frm_err_d;
  logic          push;
  logic [W-1:0]  push_word;

  // Frame assembly: a start in SHIFT aborts the partial word and restarts.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    sr_d      = sr_q;
    frm_err_d = 1'b0;
    push      = 1'b0;
    push_word = {sr_q, bus.din};
    unique case (state_q)
      S_IDLE: begin
        if (bus.sof) begin
          sr_d       = '0;
          sr_d[W-1]  = bus.din;
          bcnt_d     = BW'(1);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.sof) begin
          frm_err_d  = 1'b1;
          sr_d       = '0;
          sr_d[W-1]  = bus.din;
          bcnt_d     = BW'(1);
        end else if (bcnt_q == LAST) begin
          push       = 1'b1;
          bcnt_d     = '0;
          state_d    = S_IDLE;
        end else begin
          for (int i = 1; i < W; i++) begin
            if (i == (W - 1 - int'(bcnt_q))) sr_d[i] = bus.din;
          end
          bcnt_d     = bcnt_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, counter, shift register and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      sr_q      <= '0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      sr_q      <= sr_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign bus.frm_err = frm_err_q;

  s2p_out_queue #(.W(W)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop_rdy   (bus.dout_rdy),
    .err_clr   (bus.err_clr),
    .dout      (bus.dout),
    .dout_vld  (bus.dout_vld),
    .ovf       (bus.ovf)
  );

endmodule

// File: tb/tb_s2p_frame_rx.sv
// Self-checking bench for s2p_frame_rx: a frame/queue reference model is
// compared every cycle, plus literal expectations for the directed tests.
module tb_s2p_frame_rx;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  s2p_frame_rx_if #(.W(W)) bus ();

  s2p_frame_rx #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: bits of the frame being collected and a queue
  // of words waiting for the consumer.
  logic         collecting = 1'b0;
  logic         bits[$];
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  logic         m_err = 1'b0;
  logic         m_push;
  logic         m_pop;
  logic [W-1:0] m_word;

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each sampling edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      collecting = 1'b0;
      bits.delete();
      mq.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
    end else begin
      m_push = 1'b0;
      m_err  = 1'b0;
      m_word = '0;
      if (bus.sof) begin
        if (collecting) m_err = 1'b1;
        collecting = 1'b1;
        bits.delete();
        bits.push_back(bus.din);
      end else if (collecting) begin
        bits.push_back(bus.din);
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) m_word[W-1-i] = bits[i];
          m_push = 1'b1;
          collecting = 1'b0;
          bits.delete();
        end
      end
      m_pop = (mq.size() != 0) && bus.dout_rdy;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < 2) mq.push_back(m_word);
        else if (!bus.err_clr) m_ovf = 1'b1;
      end
      if (bus.err_clr) m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison against the model, just after the edge.
  always @(posedge clk) begin
    #1;
    check_output("model_vld", bus.dout_vld, (mq.size() != 0));
    check_output("model_dout", bus.dout, (mq.size() != 0) ? mq[0] : '0);
    check_output("model_frm_err", bus.frm_err, m_err);
    check_output("model_ovf", bus.ovf, m_ovf);
  end

  // Drive one cycle of inputs and move to just after the sampling edge.
  task automatic apply_stimulus(input logic d, input logic s, input logic rdy,
                                input logic clr);
    bus.din      = d;
    bus.sof      = s;
    bus.dout_rdy = rdy;
    bus.err_clr  = clr;
    @(posedge clk);
    #2;
  endtask

  // Emit one word as the upstream P2S stage would: sof with the MSB.
  task automatic send_word(input logic [W-1:0] w, input logic rdy_all,
                           input logic rdy_last, input logic clr_last);
    for (int i = 0; i < W; i++) begin
      apply_stimulus(w[W-1-i], (i == 0), (i == W-1) ? rdy_last : rdy_all,
                     (i == W-1) ? clr_last : 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.din = 1'b0; bus.sof = 1'b0; bus.dout_rdy = 1'b0; bus.err_clr = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_output("reset_vld", bus.dout_vld, 0);
    check_output("reset_dout", bus.dout, 0);
    check_output("reset_frm_err", bus.frm_err, 0);
    check_output("reset_ovf", bus.ovf, 0);
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("idle_din_ignored", bus.dout_vld, 0);

    // Test 1: single frame 1,0,1,1
    send_word(4'hB, 1'b1, 1'b1, 1'b0);
    check_output("t1_dout", bus.dout, 4'hB);
    check_output("t1_vld", bus.dout_vld, 1);
    check_output("t1_frm_err", bus.frm_err, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t1_vld_one_cycle", bus.dout_vld, 0);

    // Test 2: back-to-back upstream frames B then 6
    send_word(4'hB, 1'b1, 1'b1, 1'b0);
    check_output("t2_first", bus.dout, 4'hB);
    send_word(4'h6, 1'b1, 1'b1, 1'b0);
    check_output("t2_second", bus.dout, 4'h6);
    check_output("t2_frm_err", bus.frm_err, 0);
    check_output("t2_ovf", bus.ovf, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Test 3: stalled consumer, third word dropped
    send_word(4'hA, 1'b0, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0, 1'b0);
    send_word(4'hC, 1'b0, 1'b0, 1'b0);
    check_output("t3_head", bus.dout, 4'hA);
    check_output("t3_ovf", bus.ovf, 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    check_output("t3_second", bus.dout, 4'h5);
    check_output("t3_ovf_cleared", bus.ovf, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t3_empty_vld", bus.dout_vld, 0);
    check_output("t3_empty_dout", bus.dout, 0);

    // Test 4: early restart after two bits
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
    check_output("t4_frm_err", bus.frm_err, 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t4_frm_err_pulse", bus.frm_err, 0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("t4_word", bus.dout, 4'h3);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Test 5: push+pop on a full queue, then clear wins over set
    send_word(4'h1, 1'b0, 1'b0, 1'b0);
    send_word(4'h2, 1'b0, 1'b0, 1'b0);
    send_word(4'h3, 1'b0, 1'b1, 1'b0);
    check_output("t5_head", bus.dout, 4'h2);
    check_output("t5_no_ovf", bus.ovf, 0);
    send_word(4'h4, 1'b0, 1'b0, 1'b0);
    check_output("t5_ovf_set", bus.ovf, 1);
    send_word(4'h5, 1'b0, 1'b0, 1'b1);
    check_output("t5_clr_wins", bus.ovf, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t5_order", bus.dout, 4'h3);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t5_drained", bus.dout_vld, 0);

    // Test 6: reset in the middle of a frame
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check_output("t6_reset_vld", bus.dout_vld, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    send_word(4'h9, 1'b1, 1'b1, 1'b0);
    check_output("t6_word", bus.dout, 4'h9);
    check_output("t6_frm_err", bus.frm_err, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t6_drained", bus.dout_vld, 0);

    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
